// File: rtl/ahb_decode_mux.sv
// AHB-Lite address decoder and slave response multiplexer with a built-in
// default slave that answers unmapped transfers with a two-cycle ERROR and logs them.
module ahb_decode_mux #(
  parameter int                NSLV        = 8,
  parameter logic [NSLV*8-1:0] REGION_CODE = 64'h5554_5352_5150_2000,
  parameter logic [NSLV*8-1:0] REGION_MASK = {NSLV*8{1'b1}}
) (
  input  logic                HCLK,
  input  logic                HRESET,
  input  logic [31:0]         HADDR,
  input  logic [1:0]          HTRANS,
  input  logic                HREADY,
  output logic [NSLV-1:0]     HSEL,
  input  logic [NSLV*32-1:0]  HRDATA_S,
  input  logic [NSLV-1:0]     HREADYOUT_S,
  input  logic [NSLV-1:0]     HRESP_S,
  output logic [31:0]         HRDATA,
  output logic                HREADYOUT,
  output logic                HRESP,
  output logic                ERR_FLAG,
  output logic [31:0]         ERR_ADDR,
  output logic [7:0]          ERR_CNT,
  input  logic                ERR_CLR
);

  typedef enum logic [1:0] {IDLE, ERR1, ERR2} dflt_state_e;

  dflt_state_e       state_q, state_d;
  logic [NSLV:0]     dsel_q, dsel_d;       // bit NSLV = nomap
  logic              err_flag_q, err_flag_d;
  logic [31:0]       err_addr_q, err_addr_d;
  logic [7:0]        err_cnt_q, err_cnt_d;
  logic              found;
  logic              unmapped;
  logic              err_req;
  logic              enter_err1;
  logic              dflt_ready;
  logic              dflt_resp;
  logic              unused_htrans0;

  assign unused_htrans0 = HTRANS[0];

  // Address decode: first matching slave (lowest index) wins.
  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    HSEL  = '0;
    found = 1'b0;
    for (int i = 0; i < NSLV; i++) begin
      if (!found &&
          ((HADDR[31:24] & REGION_MASK[8*i +: 8]) ==
           (REGION_CODE[8*i +: 8] & REGION_MASK[8*i +: 8]))) begin
        HSEL[i] = 1'b1;
        found   = 1'b1;
      end
    end
  end

  assign unmapped = ~found;
  assign err_req  = HREADY & unmapped & HTRANS[1];
  assign dsel_d   = HREADY ? {unmapped, HSEL} : dsel_q;

  // Default slave: ERR1 is the wait cycle of the two-cycle ERROR response.
  always_comb begin
    state_d    = IDLE;
    dflt_ready = 1'b1;
    dflt_resp  = 1'b0;
    unique case (state_q)
      IDLE: state_d = err_req ? ERR1 : IDLE;
      ERR1: begin
        state_d    = ERR2;
        dflt_ready = 1'b0;
        dflt_resp  = 1'b1;
      end
      ERR2: begin
        state_d   = err_req ? ERR1 : IDLE;
        dflt_resp = 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  // A clear coinciding with a new error restarts the log with that error.
  assign enter_err1 = (state_d == ERR1);

  always_comb begin
    err_flag_d = err_flag_q;
    err_addr_d = err_addr_q;
    err_cnt_d  = err_cnt_q;
    if (enter_err1) begin
      err_flag_d = 1'b1;
      if (!err_flag_q || ERR_CLR) err_addr_d = HADDR;
      if (ERR_CLR)                err_cnt_d  = 8'd1;
      else if (err_cnt_q != 8'hFF) err_cnt_d = err_cnt_q + 8'd1;
    end else if (ERR_CLR) begin
      err_flag_d = 1'b0;
      err_cnt_d  = 8'd0;
    end
  end

  // NOTE: sequential state uses non-blocking assignments only; the reset is
  // synchronous, so it lives inside the clocked branch rather than the sensitivity list.
  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      state_q    <= IDLE;
      dsel_q     <= {1'b1, {NSLV{1'b0}}};
      err_flag_q <= 1'b0;
      err_addr_q <= '0;
      err_cnt_q  <= '0;
    end else begin
      state_q    <= state_d;
      dsel_q     <= dsel_d;
      err_flag_q <= err_flag_d;
      err_addr_q <= err_addr_d;
      err_cnt_q  <= err_cnt_d;
    end
  end

  // Data-phase response mux; DSEL is one-hot so an AND-OR mux suffices.
  always_comb begin
    HRDATA    = '0;
    HREADYOUT = 1'b0;
    HRESP     = 1'b0;
    for (int i = 0; i < NSLV; i++) begin
      if (dsel_q[i]) begin
        HRDATA    = HRDATA | HRDATA_S[32*i +: 32];
        HREADYOUT = HREADYOUT | HREADYOUT_S[i];
        HRESP     = HRESP | HRESP_S[i];
      end
    end
    if (dsel_q[NSLV]) begin
      HREADYOUT = dflt_ready;
      HRESP     = dflt_resp;
    end
  end

  assign ERR_FLAG = err_flag_q;
  assign ERR_ADDR = err_addr_q;
  assign ERR_CNT  = err_cnt_q;

endmodule

// File: doc/ahb_decode_mux.md
AHB_DECODE_MUX -- requirements
Module: ahb_decode_mux

Interface
REQ-001 SHALL have parameter NSLV, default 8, meaning number of slave ports (1..15).
REQ-002 SHALL have parameter REGION_CODE, NSLV*8 bits, default 64'h5554_5352_5150_2000, meaning the 8-bit HADDR[31:24] code per slave (slave 0 in LSBs).
REQ-003 SHALL have parameter REGION_MASK, NSLV*8 bits, default all ones, meaning the compare mask per slave.
REQ-004 SHALL have port HCLK, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-005 SHALL have port HRESET, input, 1 bit: reset, synchronous and active-high.
REQ-006 SHALL have port HADDR, input, 32 bits: AHB address-phase address.
REQ-007 SHALL have port HTRANS, input, 2 bits: AHB transfer type; bit 1 set = NONSEQ/SEQ (active).
REQ-008 SHALL have port HREADY, input, 1 bit: bus ready, i.e. HREADYOUT fed back.
REQ-009 SHALL have port HSEL, output, NSLV bits: one-hot slave selects.
REQ-010 SHALL have port HRDATA_S, input, NSLV*32 bits: slave read data, slave 0 in LSBs.
REQ-011 SHALL have port HREADYOUT_S, input, NSLV bits: per-slave ready.
REQ-012 SHALL have port HRESP_S, input, NSLV bits: per-slave response; 1 = ERROR.
REQ-013 SHALL have ports HRDATA (output, 32 bits), HREADYOUT (output, 1 bit) and HRESP (output, 1 bit): the muxed responses to the master.
REQ-014 SHALL have port ERR_FLAG, output, 1 bit: sticky flag for an unmapped access.
REQ-015 SHALL have port ERR_ADDR, output, 32 bits: address of the first unmapped active transfer since the last clear.
REQ-016 SHALL have port ERR_CNT, output, 8 bits: saturating count of unmapped active transfers.
REQ-017 SHALL have port ERR_CLR, input, 1 bit: clears ERR_FLAG and ERR_CNT.

Function
REQ-018 Slave i SHALL match when (HADDR[31:24] & MASK_i) == (CODE_i & MASK_i).
REQ-019 When more than one slave matches, the lowest index SHALL win; HSEL SHALL be combinational from HADDR, with at most one bit high.
REQ-020 When no slave matches, HSEL SHALL be all zero and the address is "unmapped".
REQ-021 The data-phase select register DSEL (one-hot over NSLV plus a nomap bit) SHALL load the address-phase decode on each edge where HREADY=1, and hold while HREADY=0.
REQ-022 When DSEL selects slave i, HRDATA, HREADYOUT and HRESP SHALL equal HRDATA_S[i], HREADYOUT_S[i] and HRESP_S[i] combinationally.
REQ-023 When DSEL selects nomap, HRDATA SHALL be 32'h0, and HREADYOUT/HRESP SHALL come from the default-slave FSM.
REQ-024 The default-slave FSM SHALL have the states IDLE, ERR1 and ERR2.
- IDLE: HREADYOUT=1, HRESP=0.
- ERR1: HREADYOUT=0, HRESP=1.
- ERR2: HREADYOUT=1, HRESP=1.
REQ-025 IDLE SHALL go to ERR1 when HREADY=1, the address is unmapped and HTRANS[1]=1; otherwise it SHALL stay in IDLE.
REQ-026 ERR1 SHALL go to ERR2 unconditionally.
REQ-027 ERR2 SHALL go to ERR1 if HREADY=1, the address is unmapped and HTRANS[1]=1 (back-to-back error); otherwise it SHALL go to IDLE.
REQ-028 An unmapped IDLE/BUSY transfer SHALL produce a zero-wait OKAY response and SHALL NOT affect the ERR_* outputs.
REQ-029 On each edge where the FSM enters ERR1: ERR_CNT SHALL increment, saturating at 8'hFF.
REQ-030 On the same edge, if ERR_FLAG=0, ERR_ADDR SHALL load HADDR and ERR_FLAG SHALL set.
REQ-031 ERR_ADDR SHALL hold while ERR_FLAG=1.
REQ-032 ERR_CLR=1 SHALL clear ERR_FLAG to 0 and ERR_CNT to 0 on the next edge, and ERR_ADDR SHALL be unchanged.
REQ-033 If ERR_CLR=1 coincides with entry to ERR1, ERR_FLAG SHALL be 1, ERR_ADDR SHALL equal the new HADDR, and ERR_CNT SHALL be 1.
REQ-034 Decode-to-response latency SHALL be one cycle (AHB address/data pipeline); mapped slaves SHALL see no added wait states.

Reset
REQ-035 HRESET=1 at an edge SHALL set DSEL=nomap, FSM=IDLE, ERR_FLAG=0, ERR_ADDR=0 and ERR_CNT=0, overriding all other inputs.
REQ-036 After reset the outputs SHALL be HREADYOUT=1, HRESP=0 and HRDATA=0.
REQ-037 Reset asserted during ERR1 or ERR2 SHALL return the FSM to IDLE on the next edge, with no ERR2 cycle emitted.

Verification
REQ-038 Read from HADDR=0x5300_0010 with HTRANS=NONSEQ -> HSEL=8'h20; next cycle HRDATA=HRDATA_S[5] and HREADYOUT follows HREADYOUT_S[5], including stretched wait states.
REQ-039 NONSEQ to 0x4000_0000 -> HSEL=0; data phase gives HREADYOUT=0/HRESP=1, then HREADYOUT=1/HRESP=1; ERR_FLAG=1, ERR_ADDR=0x4000_0000, ERR_CNT=1.
REQ-040 Two back-to-back unmapped NONSEQs (0x4000_0000 then 0x6000_0000) -> ERR1, ERR2, ERR1, ERR2; ERR_CNT=2; ERR_ADDR stays 0x4000_0000.
REQ-041 IDLE transfer to 0xFF00_0000 -> zero-wait OKAY; ERR_CNT unchanged. With REGION_MASK for slaves 0 and 1 set to 8'h00, an access to 0x2000_0000 -> HSEL=8'h01 (lowest-index priority).
REQ-042 ERR_CLR pulsed in the same cycle as a new unmapped NONSEQ to 0x7000_0000 -> ERR_FLAG=1, ERR_ADDR=0x7000_0000, ERR_CNT=1; 256 errors without a clear -> ERR_CNT saturates at 8'hFF.
REQ-043 HRESET pulsed while the FSM is in ERR1 -> next cycle FSM=IDLE, HREADYOUT=1, HRESP=0 and all ERR_* outputs = 0.
